// File: rtl/crossbar_egress_buffer.sv
// Egress buffer for one crossbar output port. Words arrive with no
// backpressure. They go into a FIFO and then a registered output slot, and
// leave through a valid/ready handshake. Words that arrive while both the
// FIFO and the slot are full are dropped and counted. Occupancy and
// nearly-full status are registered for the dispatch scheduler.
module crossbar_egress_buffer #(
    parameter int DATA_WIDTH = 480,
    parameter int CTRL_WIDTH = 32,
    parameter int DEPTH_BITS = 4,
    parameter int NF_MARGIN  = 2,
    parameter int PORT_ID    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_wr,
    input  logic [CTRL_WIDTH-1:0] in_ctl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  nearly_full,
    output logic [DEPTH_BITS+1:0] occupancy,
    output logic [31:0]           accept_cnt,
    output logic [31:0]           drop_cnt,
    output logic [31:0]           misroute_cnt
);

    localparam int                DEPTH       = 2 ** DEPTH_BITS;
    localparam int                WORD_W      = CTRL_WIDTH + DATA_WIDTH;
    localparam logic [DEPTH_BITS:0] LP_DEPTH    = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] LP_NF_LEVEL = (DEPTH_BITS + 1)'(DEPTH - NF_MARGIN);
    localparam logic [1:0]        LP_PORT     = 2'(PORT_ID);

    logic [WORD_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS:0]   r_count;
    logic                  r_out_valid;
    logic [CTRL_WIDTH-1:0] r_out_ctl;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_nearly_full;
    logic [DEPTH_BITS+1:0] r_occupancy;
    logic [31:0]           r_accept_cnt;
    logic [31:0]           r_drop_cnt;
    logic [31:0]           r_misroute_cnt;

    logic                  w_pop;
    logic                  w_slot_free;
    logic                  w_fifo_to_slot;
    logic                  w_bypass;
    logic                  w_fifo_wr;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_misroute;
    logic [WORD_W-1:0]     w_head;
    logic [DEPTH_BITS:0]   w_count_next;
    logic                  w_valid_next;

    // The slot can take a new word when it is empty or being drained this
    // cycle. The FIFO head always wins over a bypass so that order is kept.
    assign w_pop          = r_out_valid && out_ready;
    assign w_slot_free    = !r_out_valid || w_pop;
    assign w_fifo_to_slot = w_slot_free && (r_count != '0);
    assign w_bypass       = w_slot_free && (r_count == '0) && in_wr;
    // A full FIFO still accepts a write when its head moves to the slot
    // in the same cycle.
    assign w_fifo_wr      = in_wr && !w_bypass && ((r_count < LP_DEPTH) || w_fifo_to_slot);
    assign w_accept       = w_bypass || w_fifo_wr;
    assign w_drop         = in_wr && !w_accept;
    assign w_misroute     = w_accept && (in_ctl[1:0] != LP_PORT);
    assign w_head         = r_mem[r_rd_ptr];

    // Post-edge FIFO count and slot validity, which feed the registered status outputs.
    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_count_next = r_count;
        case ({w_fifo_wr, w_fifo_to_slot})
            2'b10:   w_count_next = r_count + (DEPTH_BITS + 1)'(1);
            2'b01:   w_count_next = r_count - (DEPTH_BITS + 1)'(1);
            default: w_count_next = r_count;
        endcase
        w_valid_next = r_out_valid;
        if (w_fifo_to_slot || w_bypass) begin
            w_valid_next = 1'b1;
        end else if (w_pop) begin
            w_valid_next = 1'b0;
        end
    end

    // FIFO storage write port.
    // NOTE: the memory array has no reset. A reset clears the pointers and
    // the count, and that is enough to make any stale entries unreachable.
    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_mem[r_wr_ptr] <= {in_ctl, in_data};
        end
    end

    // FIFO pointers, count and the output slot.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_ctl   <= '0;
            r_out_data  <= '0;
        end else begin
            r_count     <= w_count_next;
            r_out_valid <= w_valid_next;
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
            end
            if (w_fifo_to_slot) begin
                r_rd_ptr                <= r_rd_ptr + DEPTH_BITS'(1);
                {r_out_ctl, r_out_data} <= w_head;
            end else if (w_bypass) begin
                r_out_ctl  <= in_ctl;
                r_out_data <= in_data;
            end
        end
    end

    // Registered status, so it describes the state that holds after the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nearly_full <= 1'b0;
            r_occupancy   <= '0;
        end else begin
            r_nearly_full <= (w_count_next >= LP_NF_LEVEL);
            r_occupancy   <= {1'b0, w_count_next} + {{(DEPTH_BITS + 1){1'b0}}, w_valid_next};
        end
    end

    // Saturating event counters for accepted, dropped and misrouted words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_accept_cnt   <= '0;
            r_drop_cnt     <= '0;
            r_misroute_cnt <= '0;
        end else begin
            if (w_accept && (r_accept_cnt != '1)) begin
                r_accept_cnt <= r_accept_cnt + 32'd1;
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
            if (w_misroute && (r_misroute_cnt != '1)) begin
                r_misroute_cnt <= r_misroute_cnt + 32'd1;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_ctl      = r_out_ctl;
    assign out_data     = r_out_data;
    assign nearly_full  = r_nearly_full;
    assign occupancy    = r_occupancy;
    assign accept_cnt   = r_accept_cnt;
    assign drop_cnt     = r_drop_cnt;
    assign misroute_cnt = r_misroute_cnt;

endmodule

// File: doc/crossbar_egress_buffer.md
Name: crossbar_egress_buffer

Overview:
- Per-output-port egress stage placed directly downstream of one 4x4 crossbar output (out_wrN/out_ctlN/out_dataN).
- The crossbar pushes words with no backpressure. This block absorbs them in a FIFO plus a registered output slot, and presents them to the port MAC/deparser over a valid/ready handshake.
- Words that arrive while the buffer is full are dropped and counted. Occupancy and nearly-full status are exported for the dispatch scheduler.
- The team instantiates one block per crossbar output.

Parameters:
- DATA_WIDTH, 480, payload width; matches the crossbar.
- CTRL_WIDTH, 32, control word width; matches the crossbar. Bits [1:0] carry the destination port.
- DEPTH_BITS, 4, log2 of the internal FIFO depth; DEPTH = 2**DEPTH_BITS.
- NF_MARGIN, 2, nearly_full asserts when fifo_count >= DEPTH-NF_MARGIN.
- PORT_ID, 0, this block's output index; used only for destination checking.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- in_wr  in  1  word valid from crossbar output; there is no ready.
- in_ctl  in  CTRL_WIDTH  control word.
- in_data  in  DATA_WIDTH  payload.
- out_valid  out  1  output slot holds a word.
- out_ready  in  1  consumer accepts the word when out_valid&&out_ready.
- out_ctl  out  CTRL_WIDTH  registered control of the head word.
- out_data  out  DATA_WIDTH  registered payload of the head word.
- nearly_full  out  1  fifo_count >= DEPTH-NF_MARGIN.
- occupancy  out  DEPTH_BITS+2  fifo_count + out_valid.
- accept_cnt  out  32  words accepted; saturating.
- drop_cnt  out  32  words dropped because the buffer was full; saturating.
- misroute_cnt  out  32  accepted words with in_ctl[1:0] != PORT_ID; saturating.

Behaviour:
- Reset: rst is asynchronous and active-low. While rst=0, the following are all 0: out_valid, out_ctl, out_data, fifo pointers, fifo_count, nearly_full, occupancy and all counters. Reset asserted mid-stream discards all buffered words. There is no flush beyond this.
- Storage: DEPTH-entry FIFO with rd_ptr, wr_ptr (DEPTH_BITS, wrap modulo DEPTH) and fifo_count (DEPTH_BITS+1, range 0..DEPTH). An output register slot sits after the FIFO. Total capacity is DEPTH+1.
- pop = out_valid && out_ready.
- Slot load priority each cycle, evaluated with pre-edge values:
  1. If (!out_valid || pop) and fifo_count>0: load the FIFO head into the slot, then rd_ptr++ and fifo_count--.
  2. Else if (!out_valid || pop) and fifo_count==0 and in_wr: the word bypasses directly into the slot. Latency is 1 cycle, in_wr at edge N gives out_valid high after edge N.
  3. Else if pop and no source is available: out_valid <= 0.
- FIFO write: in_wr that did not bypass writes mem[wr_ptr], then wr_ptr++ and fifo_count++. This is accepted if fifo_count<DEPTH, or if fifo_count==DEPTH and a FIFO-to-slot move happens in the same cycle. A simultaneous read and write at full is accepted, and fifo_count is unchanged.
- Drop: in_wr that is neither bypassed nor written is discarded. drop_cnt++ and no state changes.
- Ordering: output order strictly equals arrival order of accepted words. A bypass never overtakes FIFO contents.
- out_ctl and out_data are held stable while out_valid && !out_ready.
- Counters saturate at 32'hFFFFFFFF. accept_cnt and misroute_cnt update on the same edge as acceptance.
- nearly_full and occupancy are registered from post-edge state, i.e. valid in the same cycle as the state they describe.
- Sizing: 120-250 lines of RTL with the memory as a reg array. No vendor FIFO macro.

Test Plan:
- Single word, idle buffer: in_wr at cycle 0 (ctl=32'h0, data=A) with out_ready=1 -> out_valid=1, out_data=A at cycle 1; out_valid=0 at cycle 2; accept_cnt=1; occupancy back to 0.
- Fill and drop: DEPTH=16 with out_ready=0, 20 back-to-back words D0..D19 -> D0..D16 accepted (occupancy=17), D17..D19 dropped (drop_cnt=3); nearly_full=1 from occupancy 15 onward. Then out_ready=1 -> D0..D16 emerge in order, one per cycle.
- Full with simultaneous read/write: at occupancy 17, out_ready=1 and in_wr=1 for 5 cycles -> no drops; occupancy stays 17; the output sequence continues without gaps.
- Backpressure stability: out_ready toggled 1,0,0,1 while 4 words stream in -> out_data is unchanged across ready=0 cycles; all 4 words are delivered exactly once, in order.
- Misroute: PORT_ID=2, send ctl[1:0]=2,1,2 -> misroute_cnt=1 and accept_cnt=3; all three words are delivered.
- Reset mid-operation: occupancy 9, assert rst=0 asynchronously between clock edges -> out_valid, occupancy and counters are 0 immediately. After release, a new word has 1-cycle latency and no stale data appears.
